fifo_rd_burst_sched: RTL and testbench

//  Read-domain scheduler sharing one async FIFO read port between N consumers.

---
 rtl/fifo_rd_burst_sched_pkg.sv | 21 ++
 rtl/fifo_rd_burst_sched_if.sv | 31 +++
 rtl/fifo_rd_burst_sched_arb.sv | 58 +++++
 rtl/fifo_rd_burst_sched.sv | 131 +++++++++++++
 tb/tb_fifo_rd_burst_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_burst_sched_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg
//   Shared types and helpers for the read-domain burst scheduler.
//   - rd_sched_state_e : scheduler FSM states
//   - idx_width()      : width of an index selecting one of n consumers
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } rd_sched_state_e;

    // A single consumer still needs a 1-bit index so the ports never collapse
    // to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_burst_sched_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_burst_sched_if
//   Bundles the FIFO read-port signals and the shared consumer bus.
//   FIFO side    : rempty, rdata (into scheduler), rinc (out of scheduler)
//   Consumer side: cons_req, cons_ready (into scheduler),
//                  cons_valid, cons_data, cons_last (out of scheduler)
//   master = the scheduler, slave = FIFO + consumers around it.
// ---------------------------------------------------------------------------
interface fifo_rd_burst_sched_if #(
    parameter int DW = 8,
    parameter int N  = 4
);
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic [N-1:0]  cons_req;
    logic [N-1:0]  cons_ready;
    logic [N-1:0]  cons_valid;
    logic [DW-1:0] cons_data;
    logic          cons_last;

    modport master (
        input  rempty, rdata, cons_req, cons_ready,
        output rinc, cons_valid, cons_data, cons_last
    );

    modport slave (
        output rempty, rdata, cons_req, cons_ready,
        input  rinc, cons_valid, cons_data, cons_last
    );
endinterface

// File: rtl/fifo_rd_burst_sched_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n
//   Combinational round-robin pick among N requesters.
//   req     in  N       request vector
//   rr_ptr  in  idx     highest-priority position this round
//   gnt_idx out idx     chosen requester (first set bit at/after rr_ptr, cyclic)
//   gnt_any out 1       at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter_n
    import fifo_rd_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   rr_ptr,
    output logic [idx_width(N)-1:0]   gnt_idx,
    output logic                      gnt_any
);
    localparam int GW = idx_width(N);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] onehot;
    logic         found;

    // Masked priority encoder: requesters at or above rr_ptr win first; when
    // none of them is asking, the lowest requester overall wraps around.
    always_comb begin
        mask    = '0;
        onehot  = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (GW'(i) >= rr_ptr);
        end
        masked = req & mask;
        for (int i = 0; i < N; i++) begin
            if (masked[i] && !found) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                gnt_idx = GW'(i);
            end
        end
    end

    assign gnt_any = |req;

endmodule

// File: rtl/fifo_rd_burst_sched.sv
// ---------------------------------------------------------------------------
// fifo_rd_burst_sched
//   Shares one async-FIFO read port between N consumers. A round-robin grant
//   hands a consumer a burst of up to BURST_LEN words; each popped word is
//   presented through a registered valid/ready stage to the owner only.
//   rclk     in   read-domain clock
//   rrst_n   in   async active-low reset
//   bus      master modport: rempty/rdata in, rinc out,
//            cons_req/cons_ready in, cons_valid/cons_data/cons_last out
//   grant_id out  owner of the current or most recent grant
//   busy     out  scheduler is not idle
// ---------------------------------------------------------------------------
module fifo_rd_burst_sched
    import fifo_rd_pkg::*;
#(
    parameter int DW        = 8,
    parameter int N         = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    fifo_rd_burst_sched_if.master    bus,
    output logic [idx_width(N)-1:0]  grant_id,
    output logic                     busy
);
    localparam int GW = idx_width(N);
    localparam int CW = $clog2(BURST_LEN + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(BURST_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
    localparam logic [GW-1:0] LAST_ID  = GW'(N - 1);

    rd_sched_state_e state;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   grant_q;
    logic [CW-1:0]   burst_cnt;
    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;

    logic [GW-1:0]   arb_idx;
    logic            arb_any;
    logic            owner_req;
    logic            owner_ready;
    logic            accept;
    logic            pop;

    rr_arbiter_n #(.N(N)) u_arb (
        .req     (bus.cons_req),
        .rr_ptr  (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Only the granted consumer's req/ready matter; everyone else is ignored
    // until the scheduler returns to IDLE. A pop may only happen when the
    // output register is free or is being emptied by the owner this cycle.
    always_comb begin
        owner_req   = bus.cons_req[grant_q];
        owner_ready = bus.cons_ready[grant_q];
        accept      = out_valid && owner_ready;
        pop         = (state == S_BURST) && !bus.rempty && owner_req &&
                      (burst_cnt < CNT_MAX) && (!out_valid || owner_ready);
    end

    // Route the single output register to the owner's valid line.
    always_comb begin
        bus.cons_valid = '0;
        for (int i = 0; i < N; i++) begin
            bus.cons_valid[i] = out_valid && (grant_q == GW'(i));
        end
    end

    assign bus.rinc      = pop;
    assign bus.cons_data = out_data;
    assign bus.cons_last = out_last;
    assign grant_id      = grant_q;
    assign busy          = (state != S_IDLE);

    // Scheduler FSM with burst counter and output register. Grant happens in
    // IDLE only, so the first pop of a burst is always a cycle after the
    // grant. The burst counter stops at BURST_LEN because pops are gated
    // there. DRAIN keeps the last word until it is taken, then advances the
    // round-robin pointer past the owner.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_any && !bus.rempty) begin
                        grant_q   <= arb_idx;
                        burst_cnt <= '0;
                        state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (pop) begin
                        out_data  <= bus.rdata;
                        out_valid <= 1'b1;
                        out_last  <= (burst_cnt == CNT_LAST);
                        burst_cnt <= burst_cnt + 1'b1;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                    end
                    if ((burst_cnt == CNT_MAX) || !owner_req ||
                        (bus.rempty && !pop)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!out_valid || accept) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_burst_sched.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_burst_sched
//   Directed burst scenarios followed by a long randomized run. A queue model
//   of the FIFO drives rempty/rdata; every word written is expected to reach
//   a consumer exactly once and in write order.
// ---------------------------------------------------------------------------
module tb_fifo_rd_burst_sched;
    import fifo_rd_pkg::*;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int BL    = 4;
    localparam int DEPTH = 16;

    logic       rclk   = 1'b0;
    logic       rrst_n = 1'b1;
    logic [1:0] grant_id;
    logic       busy;

    fifo_rd_burst_sched_if #(.DW(DW), .N(N)) bus ();

    fifo_rd_burst_sched #(.DW(DW), .N(N), .BURST_LEN(BL)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 rclk = ~rclk;

    logic [7:0] fifo_q[$];
    logic [7:0] written_q[$];
    logic [7:0] acc_data[$];
    int         acc_owner[$];
    int         acc_last[$];
    int         acc_cycle[$];
    int         cycle_no;
    int         rinc_total;
    int         rinc_run;
    int         rinc_run_max;
    int         next_word;
    bit         force_empty;
    int         tests_run;
    int         tests_failed;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ownerOf(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic refreshFifo();
        bus.rempty = (fifo_q.size() == 0) || force_empty;
        bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic pushWords(input int n);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            if (fifo_q.size() < DEPTH) begin
                w = 8'(next_word);
                next_word++;
                fifo_q.push_back(w);
                written_q.push_back(w);
            end
        end
        refreshFifo();
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] rdy);
        bus.cons_req   = req;
        bus.cons_ready = rdy;
    endtask

    task automatic clearLogs();
        acc_data.delete();
        acc_owner.delete();
        acc_last.delete();
        acc_cycle.delete();
        rinc_total   = 0;
        rinc_run     = 0;
        rinc_run_max = 0;
    endtask

    // One clock: observe at the falling edge, then update the FIFO model just
    // after the rising edge so inputs are stable for the whole next cycle.
    task automatic stepCycle();
        bit popped;
        int own;
        @(negedge rclk);
        checkOutput("rinc_while_empty", 32'(bus.rinc && bus.rempty), 0);
        checkOutput("valid_onehot0", 32'($onehot0(bus.cons_valid)), 1);
        popped = bus.rinc;
        if (popped) begin
            rinc_total++;
            rinc_run++;
            if (rinc_run > rinc_run_max) rinc_run_max = rinc_run;
        end else begin
            rinc_run = 0;
        end
        own = ownerOf(bus.cons_valid);
        if (own >= 0 && bus.cons_ready[own]) begin
            if (written_q.size() == 0) begin
                checkOutput("acc_unexpected", 1, 0);
            end else begin
                checkOutput("acc_order", 32'(bus.cons_data), 32'(written_q.pop_front()));
            end
            acc_data.push_back(bus.cons_data);
            acc_owner.push_back(own);
            acc_last.push_back(int'(bus.cons_last));
            acc_cycle.push_back(cycle_no);
        end
        @(posedge rclk);
        #1;
        cycle_no++;
        if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refreshFifo();
    endtask

    task automatic doReset();
        rrst_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(bus.cons_valid), 0);
        checkOutput("rst_rinc", 32'(bus.rinc), 0);
        checkOutput("rst_data", 32'(bus.cons_data), 0);
        checkOutput("rst_last", 32'(bus.cons_last), 0);
        checkOutput("rst_grant", 32'(grant_id), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        // Popped-but-unaccepted words are lost; the FIFO itself keeps the rest.
        while (written_q.size() > fifo_q.size()) void'(written_q.pop_front());
        repeat (2) @(posedge rclk);
        #1;
        rrst_n   = 1'b1;
        rinc_run = 0;
    endtask

    task automatic freshStart();
        applyStimulus('0, '0);
        force_empty = 1'b0;
        doReset();
        fifo_q.delete();
        written_q.delete();
        clearLogs();
        refreshFifo();
    endtask

    task automatic runUntil(input int n_acc, input int budget, input string tag);
        int k;
        k = 0;
        while (acc_data.size() < n_acc && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput({tag, "_timeout"}, 32'(acc_data.size() >= n_acc), 1);
    endtask

    task automatic waitDrain(input int budget, input string tag);
        int k;
        k = 0;
        while ((written_q.size() > 0 || busy) && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput({tag, "_left"}, 32'(written_q.size()), 0);
    endtask

    logic [7:0] hold_word;
    int         r0;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cycle_no     = 0;
        next_word    = 8'h10;
        force_empty  = 1'b0;
        refreshFifo();

        // Test 1: single requester, 8 words -> two full bursts to consumer 0.
        freshStart();
        pushWords(8);
        applyStimulus(4'b0001, 4'b1111);
        runUntil(8, 60, "t1");
        for (int k = 0; k < acc_data.size() && k < 8; k++) begin
            checkOutput("t1_owner", 32'(acc_owner[k]), 0);
            checkOutput("t1_last", 32'(acc_last[k]), 32'(k % BL == BL - 1));
        end
        checkOutput("t1_rinc_total", 32'(rinc_total), 8);
        checkOutput("t1_rinc_run", 32'(rinc_run_max), 4);
        repeat (4) stepCycle();
        checkOutput("t1_busy", 32'(busy), 0);

        // Test 2: all four request, 16 words -> grants 0,1,2,3, gapless bursts.
        freshStart();
        pushWords(16);
        applyStimulus(4'b1111, 4'b1111);
        runUntil(16, 120, "t2");
        for (int k = 0; k < acc_data.size() && k < 16; k++) begin
            checkOutput("t2_owner", 32'(acc_owner[k]), 32'(k / BL));
            checkOutput("t2_last", 32'(acc_last[k]), 32'(k % BL == BL - 1));
            if (k % BL != 0) begin
                checkOutput("t2_gap", 32'(acc_cycle[k] - acc_cycle[k-1]), 1);
            end
        end

        // Test 3: single word to consumer 2 -> partial burst without last.
        freshStart();
        pushWords(1);
        applyStimulus(4'b0100, 4'b0100);
        runUntil(1, 20, "t3");
        if (acc_data.size() > 0) begin
            checkOutput("t3_owner", 32'(acc_owner[0]), 2);
            checkOutput("t3_last", 32'(acc_last[0]), 0);
        end
        repeat (4) stepCycle();
        checkOutput("t3_rinc_total", 32'(rinc_total), 1);
        checkOutput("t3_busy", 32'(busy), 0);

        // Test 4: owner stalls 5 cycles mid-burst -> no pops, word held.
        freshStart();
        pushWords(8);
        applyStimulus(4'b0001, 4'b0001);
        runUntil(2, 30, "t4a");
        applyStimulus(4'b0001, 4'b0000);
        hold_word = (written_q.size() > 0) ? written_q[0] : 8'h00;
        r0 = rinc_total;
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput("t4_hold_data", 32'(bus.cons_data), 32'(hold_word));
            checkOutput("t4_hold_valid", 32'(bus.cons_valid), 32'b0001);
        end
        checkOutput("t4_stall_pops", 32'(rinc_total - r0), 0);
        checkOutput("t4_stall_acc", 32'(acc_data.size()), 2);
        applyStimulus(4'b0001, 4'b0001);
        runUntil(8, 60, "t4b");
        checkOutput("t4_rinc_total", 32'(rinc_total), 8);

        // Test 5: move rr_ptr to 2, reset mid-burst, regrant favours 0.
        freshStart();
        pushWords(4);
        applyStimulus(4'b0010, 4'b0010);
        runUntil(4, 40, "t5pre");
        waitDrain(20, "t5pre_drain");
        clearLogs();
        pushWords(8);
        applyStimulus(4'b1111, 4'b1111);
        runUntil(1, 20, "t5a");
        if (acc_owner.size() > 0) checkOutput("t5_owner_pre", 32'(acc_owner[0]), 2);
        checkOutput("t5_valid_pre", 32'(bus.cons_valid), 32'b0100);
        doReset();
        clearLogs();
        runUntil(1, 20, "t5b");
        if (acc_owner.size() > 0) checkOutput("t5_owner_post", 32'(acc_owner[0]), 0);
        waitDrain(200, "t5_drain");

        // Test 6: random requests, stalls and empty flag; drain at the end.
        freshStart();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(3) == 0) pushWords(int'($urandom_range(3)) + 1);
            if ($urandom_range(7) == 0) bus.cons_req = N'($urandom);
            bus.cons_ready = N'($urandom);
            force_empty    = ($urandom_range(7) == 0);
            refreshFifo();
            stepCycle();
        end
        force_empty = 1'b0;
        refreshFifo();
        applyStimulus(4'b1111, 4'b1111);
        waitDrain(2000, "t6_drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
